// File: rtl/apb_master_bridge_if.sv
// Command, response and APB4 requester signals for apb_master_bridge.
// The master modport is the bridge's view; slave is the opposite side.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_wstrb;
    logic [2:0]            cmd_prot;

    // Response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_slverr;
    logic                  rsp_timeout;

    // APB4 bus
    logic [ADDR_W-1:0]     paddr;
    logic [2:0]            pprot;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pwstrb;
    logic                  pready;
    logic [DATA_W-1:0]     prdata;
    logic                  pslverr;
    logic                  pwakeup;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot,
        input  rsp_ready, pready, prdata, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output paddr, pprot, psel, penable, pwrite, pwdata, pwstrb, pwakeup
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot,
        output rsp_ready, pready, prdata, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  paddr, pprot, psel, penable, pwrite, pwdata, pwstrb, pwakeup
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB4 requester: single read/write commands in, SETUP/ACCESS sequencing with
// pwakeup handling and a wait-state timeout, one response out per command.
module apb_master_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAKE_SETUP = 1,
    parameter int IDLE_HOLD  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                pclk,
    input  logic                presetn,
    apb_master_bridge_if.master bus
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int CNT_MAX = (TIMEOUT > WAKE_SETUP) ? TIMEOUT : WAKE_SETUP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HOLD_W  = (IDLE_HOLD > 0) ? $clog2(IDLE_HOLD + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAKE   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;       // WAKE length, then ACCESS wait count
    logic [HOLD_W-1:0]   r_hold;      // remaining IDLE cycles of pwakeup hold

    logic                r_cmd_ready;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwakeup;
    logic                r_rsp_valid;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [2:0]          r_pprot;
    logic [DATA_W-1:0]   r_pwdata;
    logic [STRB_W-1:0]   r_pwstrb;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_slverr;
    logic                r_rsp_timeout;

    logic                w_accept;
    logic                w_rsp_hs;
    logic                w_wake_done;
    logic                w_timeout_hit;
    logic                w_psel_nxt;
    logic                w_penable_nxt;
    logic                w_rsp_valid_nxt;
    logic                w_cmd_ready_nxt;
    logic                w_pwakeup_nxt;

    assign w_accept      = bus.cmd_valid && r_cmd_ready;
    assign w_rsp_hs      = r_rsp_valid && bus.rsp_ready;
    assign w_wake_done   = (r_cnt >= CNT_W'(WAKE_SETUP - 1));
    // Counter reaching TIMEOUT on this edge; pready high on the same edge wins.
    assign w_timeout_hit = (TIMEOUT != 0) && !bus.pready &&
                           ((r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));

    // State register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = r_pwakeup ? ST_SETUP : ST_WAKE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAKE: begin
                if (w_wake_done) begin
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_WAKE;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.pready || w_timeout_hit) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_RESP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so every output comes straight from a flop.
    always_comb begin
        w_psel_nxt      = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
        w_penable_nxt   = (w_state_nxt == ST_ACCESS);
        w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
        w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
        w_pwakeup_nxt   = 1'b1;
        if (w_state_nxt == ST_IDLE) begin
            if (r_state == ST_RESP) begin
                w_pwakeup_nxt = (IDLE_HOLD != 0);
            end else begin
                w_pwakeup_nxt = (r_hold > HOLD_W'(1));
            end
        end else begin
            w_pwakeup_nxt = 1'b1;
        end
    end

    // Registered control outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_cmd_ready <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_pwakeup   <= 1'b0;
        end else begin
            r_cmd_ready <= w_cmd_ready_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_pwakeup   <= w_pwakeup_nxt;
        end
    end

    // Wake/wait counter (cleared on every state change, saturating) and hold counter.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_hold <= {HOLD_W{1'b0}};
        end else begin
            if (w_state_nxt != r_state) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if ((r_state == ST_WAKE) || ((r_state == ST_ACCESS) && !bus.pready)) begin
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            if ((r_state == ST_RESP) && w_rsp_hs) begin
                r_hold <= HOLD_W'(IDLE_HOLD);
            end else if (w_accept) begin
                r_hold <= {HOLD_W{1'b0}};
            end else if ((r_state == ST_IDLE) && (r_hold != {HOLD_W{1'b0}})) begin
                r_hold <= r_hold - HOLD_W'(1);
            end
        end
    end

    // Command capture onto the bus and response capture from the bus.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_paddr       <= {ADDR_W{1'b0}};
            r_pprot       <= 3'b000;
            r_pwrite      <= 1'b0;
            r_pwdata      <= {DATA_W{1'b0}};
            r_pwstrb      <= {STRB_W{1'b0}};
            r_rsp_rdata   <= {DATA_W{1'b0}};
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_paddr  <= bus.cmd_addr;
                r_pprot  <= bus.cmd_prot;
                r_pwrite <= bus.cmd_write;
                // Reads put all-zero data and strobes on the bus.
                r_pwdata <= bus.cmd_write ? bus.cmd_wdata : {DATA_W{1'b0}};
                r_pwstrb <= bus.cmd_write ? bus.cmd_wstrb : {STRB_W{1'b0}};
            end
            if (r_state == ST_ACCESS) begin
                if (bus.pready) begin
                    r_rsp_rdata   <= r_pwrite ? {DATA_W{1'b0}} : bus.prdata;
                    r_rsp_slverr  <= bus.pslverr;
                    r_rsp_timeout <= 1'b0;
                end else if (w_timeout_hit) begin
                    r_rsp_rdata   <= {DATA_W{1'b0}};
                    r_rsp_slverr  <= 1'b1;
                    r_rsp_timeout <= 1'b1;
                end
            end
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.pwakeup     = r_pwakeup;
    assign bus.pwrite      = r_pwrite;
    assign bus.paddr       = r_paddr;
    assign bus.pprot       = r_pprot;
    assign bus.pwdata      = r_pwdata;
    assign bus.pwstrb      = r_pwstrb;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_slverr  = r_rsp_slverr;
    assign bus.rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: a behavioural APB slave plus a
// transaction-level model predicting responses, wake timing and phase lengths.
module tb_apb_master_bridge;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int WAKE_SETUP = 1;
    localparam int IDLE_HOLD  = 4;
    localparam int TIMEOUT    = 16;

    logic pclk;
    logic presetn;

    apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAKE_SETUP(WAKE_SETUP),
        .IDLE_HOLD(IDLE_HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk(pclk),
        .presetn(presetn),
        .bus(bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_mem [16];   // what the memory should hold
    logic [31:0] slave_mem [16];   // what the bench slave actually holds
    bit          have_prev;        // a handshake happened since the last reset
    int          idle_k;           // IDLE cycle index since that handshake

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot, input int waits,
                           input logic err, input int bp, input int gap);
        logic        exp_to, exp_err, awake;
        logic [31:0] exp_rd, exp_pwdata;
        logic [3:0]  exp_pwstrb;
        int          idx, sidx, first_sel, acc_cnt, bad, wake_bad;
        idx        = int'(addr[3:0]);
        exp_to     = (waits >= TIMEOUT);
        exp_err    = exp_to || err;
        exp_rd     = (wr || exp_to) ? 32'd0 : model_mem[idx];
        exp_pwdata = wr ? wdata : 32'd0;
        exp_pwstrb = wr ? strb : 4'd0;

        for (int j = 0; j < gap; j++) begin
            @(negedge pclk);
            if (have_prev) begin
                idle_k++;
                chk("hold_window_wake", bus.pwakeup, (idle_k <= IDLE_HOLD));
            end
        end
        awake = have_prev && (idle_k <= IDLE_HOLD);

        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_wstrb = strb;
        bus.cmd_prot  = prot;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        bus.cmd_wdata = $urandom();
        chk("wake_after_accept", bus.pwakeup, 1);
        chk("cmd_ready_busy", bus.cmd_ready, 0);

        first_sel = 1;
        wake_bad  = 0;
        while (!bus.psel && first_sel < 50) begin
            if (!bus.pwakeup || bus.penable) wake_bad++;
            @(negedge pclk);
            first_sel++;
        end
        chk("psel_delay", first_sel, awake ? 1 : WAKE_SETUP + 1);
        chk("wake_phase", wake_bad, 0);
        chk("setup_penable", bus.penable, 0);
        chk("setup_paddr", bus.paddr, addr);
        chk("setup_pwrite", bus.pwrite, wr);
        chk("setup_pwdata", bus.pwdata, exp_pwdata);
        chk("setup_pwstrb", bus.pwstrb, exp_pwstrb);
        chk("setup_pprot", bus.pprot, prot);

        acc_cnt = 0;
        bad     = 0;
        @(negedge pclk);
        while (bus.psel && bus.penable && acc_cnt < 100) begin
            acc_cnt++;
            if (bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== exp_pwdata ||
                bus.pwstrb !== exp_pwstrb || bus.pprot !== prot || !bus.pwakeup || bus.rsp_valid)
                bad++;
            sidx        = int'(bus.paddr[3:0]);
            bus.pready  = (acc_cnt > waits);
            bus.pslverr = bus.pready && err;
            bus.prdata  = bus.pready ? slave_mem[sidx] : $urandom();
            if (bus.pready && bus.pwrite && !err)
                slave_mem[sidx] = merge(slave_mem[sidx], bus.pwdata, bus.pwstrb);
            @(negedge pclk);
        end
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = $urandom();
        chk("access_cycles", acc_cnt, exp_to ? TIMEOUT : waits + 1);
        chk("access_stable", bad, 0);
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("resp_psel_low", {bus.psel, bus.penable}, 0);

        bad = 0;
        for (int j = 0; j < bp; j++) begin
            if (bus.rsp_rdata !== exp_rd || bus.rsp_slverr !== exp_err ||
                bus.rsp_timeout !== exp_to || !bus.rsp_valid || bus.cmd_ready ||
                bus.psel || !bus.pwakeup)
                bad++;
            @(negedge pclk);
        end
        chk("backpressure_stable", bad, 0);
        chk("rsp_rdata", bus.rsp_rdata, exp_rd);
        chk("rsp_slverr", bus.rsp_slverr, exp_err);
        chk("rsp_timeout", bus.rsp_timeout, exp_to);
        bus.rsp_ready = 1'b1;
        @(negedge pclk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", bus.rsp_valid, 0);
        chk("cmd_ready_return", bus.cmd_ready, 1);
        have_prev = 1'b1;
        idle_k    = 1;
        chk("hold_window_wake", bus.pwakeup, (idle_k <= IDLE_HOLD));

        if (wr && !exp_to && !err) model_mem[idx] = merge(model_mem[idx], wdata, strb);
    endtask

    task automatic reset_mid_access();
        int n, stale;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0000_0007;
        bus.cmd_prot  = 3'd1;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!(bus.psel && bus.penable) && n < 20) begin
            @(negedge pclk);
            n++;
        end
        chk("rst_reach_access", bus.psel && bus.penable, 1);
        @(negedge pclk);
        #2 presetn = 1'b0;
        #1;
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_pwakeup", bus.pwakeup, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_paddr", bus.paddr, 0);
        @(negedge pclk);
        presetn = 1'b1;
        stale = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge pclk);
            if (bus.rsp_valid || bus.psel || bus.pwakeup || !bus.cmd_ready) stale++;
        end
        chk("no_stale_response", stale, 0);
        have_prev = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic        wr, err;
        logic [31:0] addr, data;
        logic [3:0]  strb;
        int          waits, idx;

        presetn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'd0;
        bus.cmd_wdata = 32'd0;
        bus.cmd_wstrb = 4'd0;
        bus.cmd_prot  = 3'd0;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.prdata    = 32'd0;
        bus.pslverr   = 1'b0;
        have_prev     = 1'b0;
        idle_k        = 0;
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 32'h0101_0101 * i;
            slave_mem[i] = 32'h0101_0101 * i;
        end

        repeat (3) @(negedge pclk);
        chk("reset_cmd_ready", bus.cmd_ready, 1);
        chk("reset_psel", bus.psel, 0);
        chk("reset_penable", bus.penable, 0);
        chk("reset_pwakeup", bus.pwakeup, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_paddr", bus.paddr, 0);
        chk("reset_pwdata", bus.pwdata, 0);
        chk("reset_pwstrb", bus.pwstrb, 0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 0);
        presetn = 1'b1;

        // Cold write, then a partial-strobe write inside the hold window.
        run_txn(1'b1, 32'd1, 32'hFFFF_FFFF, 4'hF, 3'd0, 0, 1'b0, 0, 0);
        run_txn(1'b1, 32'd1, 32'h0000_0000, 4'h3, 3'd2, 0, 1'b0, 0, 1);
        // Cold read with three wait states.
        run_txn(1'b0, 32'd1, 32'd0, 4'hF, 3'd0, 3, 1'b0, 0, 8);
        // Back-to-back in the hold window; last read just outside it.
        run_txn(1'b1, 32'd0, 32'hAAAA_AAAA, 4'hF, 3'd0, 0, 1'b0, 0, 6);
        run_txn(1'b0, 32'd0, 32'd0, 4'hF, 3'd0, 0, 1'b0, 0, 0);
        run_txn(1'b1, 32'd0, 32'h5555_5555, 4'hF, 3'd5, 0, 1'b0, 0, 2);
        run_txn(1'b0, 32'd0, 32'd0, 4'hF, 3'd0, 0, 1'b0, 0, IDLE_HOLD - 1);
        run_txn(1'b0, 32'd0, 32'd0, 4'hF, 3'd0, 0, 1'b0, 0, IDLE_HOLD);
        // Slave errors.
        run_txn(1'b1, 32'd2, 32'h1234_5678, 4'hF, 3'd0, 2, 1'b1, 0, 0);
        run_txn(1'b0, 32'd2, 32'd0, 4'hF, 3'd0, 0, 1'b1, 0, 0);
        // Timeout boundary.
        run_txn(1'b0, 32'd3, 32'd0, 4'hF, 3'd0, TIMEOUT, 1'b0, 0, 0);
        run_txn(1'b0, 32'd3, 32'd0, 4'hF, 3'd0, TIMEOUT - 1, 1'b0, 0, 0);
        run_txn(1'b1, 32'd3, 32'hDEAD_BEEF, 4'hF, 3'd0, TIMEOUT + 14, 1'b0, 0, 0);
        run_txn(1'b0, 32'd3, 32'd0, 4'hF, 3'd0, 0, 1'b0, 0, 0);
        // Response backpressure.
        run_txn(1'b0, 32'd1, 32'd0, 4'hF, 3'd0, 1, 1'b0, 5, 0);

        reset_mid_access();

        for (int t = 0; t < 40; t++) begin
            wr    = 1'($urandom_range(0, 1));
            idx   = $urandom_range(0, 15);
            addr  = ($urandom() & 32'hFFFF_FFF0) | 32'(idx);
            data  = $urandom();
            strb  = 4'($urandom_range(0, 15));
            err   = ($urandom_range(0, 7) == 0);
            waits = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2)
                                                : $urandom_range(0, 4);
            run_txn(wr, addr, data, strb, 3'($urandom_range(0, 7)), waits, err,
                    $urandom_range(0, 3), $urandom_range(0, 6));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Synthesizable APB4 requester that drives the register-slave APB port in our subsystem, replacing the behavioural bus tasks with real RTL. It accepts single read/write commands on a valid/ready command channel. It sequences pwakeup, SETUP and ACCESS phases on the bus and returns read data and error status on a valid/ready response channel. It also provides a wait-state timeout so a hung slave cannot stall the command source.

Parameters:
ADDR_W, 32, width of cmd_addr/paddr
DATA_W, 32, width of data buses; pwstrb width is DATA_W/8
WAKE_SETUP, 1, cycles pwakeup is asserted before psel when the bus was asleep (>=1)
IDLE_HOLD, 4, cycles pwakeup stays high after a response handshake (0 = drop immediately)
TIMEOUT, 16, max ACCESS cycles with pready low before abort (0 = disabled)

Ports:
pclk  in  1  clock; all logic rising-edge
presetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  bridge can accept a command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  DATA_W/8  byte strobes (writes only)
cmd_prot  in  3  APB pprot value
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
rsp_slverr  out  1  pslverr sampled, or forced 1 on timeout
rsp_timeout  out  1  transaction aborted by timeout
paddr  out  ADDR_W  APB address
pprot  out  3  APB protection
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
pwstrb  out  DATA_W/8  APB strobes
pready  in  1  slave ready
prdata  in  DATA_W  slave read data
pslverr  in  1  slave error
pwakeup  out  1  APB4 wakeup request

Behaviour:
- Reset (presetn low, asynchronous): state IDLE; psel, penable, pwrite, pwakeup, rsp_valid, rsp_slverr, rsp_timeout = 0; paddr, pprot, pwdata, pwstrb, rsp_rdata = 0; wait and hold counters = 0. Any in-flight transfer is dropped with no response.
- cmd_ready = 1 only in IDLE. The command is captured on the clock edge where cmd_valid && cmd_ready.
- States: IDLE, WAKE, SETUP, ACCESS, RESP.
- IDLE -> WAKE on accept if pwakeup is low. IDLE -> SETUP on accept if pwakeup is still high from the hold window.
- WAKE: pwakeup = 1, psel = 0 for WAKE_SETUP cycles, then -> SETUP.
- SETUP: exactly one cycle with psel = 1, penable = 0; paddr, pprot, pwrite, pwdata, pwstrb driven from the captured command. Then -> ACCESS.
- ACCESS: psel = 1, penable = 1. All bus outputs hold stable until exit.
  - pready high: capture prdata (reads; 0 for writes) and pslverr into the rsp_* registers; rsp_timeout = 0. Next cycle psel = penable = 0, rsp_valid = 1, -> RESP.
  - pready low: increment the wait counter. If TIMEOUT != 0 and the counter reaches TIMEOUT, abort: psel = penable = 0, rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0, -> RESP.
  - pready high in the same cycle the counter reaches TIMEOUT: pready wins, normal completion.
- Reads drive pwstrb = 0 and pwdata = 0. Writes drive cmd_wstrb and cmd_wdata unchanged.
- RESP: rsp_* held stable while rsp_valid && !rsp_ready. On handshake: rsp_valid = 0 next cycle, -> IDLE, hold counter loaded with IDLE_HOLD. Minimum one RESP cycle; no combinational path from rsp_ready to cmd_ready.
- pwakeup: high from the cycle after accept (WAKE or SETUP) through RESP. After the handshake it stays high for IDLE_HOLD IDLE cycles, then drops. Accepting a command during the hold window keeps pwakeup high continuously and skips WAKE. With IDLE_HOLD = 0, pwakeup drops the cycle after the handshake.
- Wait counter clears on entry to SETUP. It must be wide enough to count to TIMEOUT without wrap.
- Throughput with a zero-wait slave and hold active: accept, SETUP, ACCESS, RESP = 4 cycles per transaction.

Test Plan:
- Cold write: bus asleep, cmd write addr 1 data FFFFFFFF strb F, pready tied 1 -> pwakeup rises 1 cycle before psel; SETUP 1 cycle, ACCESS 1 cycle; pwstrb = F; rsp_valid with slverr = 0, rdata = 0.
- Read with wait states: slave returns FFFF0000 after 3 pready-low cycles, cmd read addr 1 -> ACCESS lasts 4 cycles; paddr stable throughout; pwstrb = 0; rsp_rdata = FFFF0000.
- Back-to-back in hold window: write addr 0 AAAAAAAA, then read addr 0 issued within 4 cycles of the response handshake -> pwakeup never drops, no WAKE state; read returns AAAAAAAA. Repeat with 55555555.
- Error and timeout: slave asserts pslverr with pready -> rsp_slverr = 1, rsp_timeout = 0. Slave holds pready low -> abort after 16 ACCESS cycles; rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0; pready arriving exactly on cycle 16 -> normal completion.
- Response backpressure: rsp_ready low for 5 cycles -> rsp_* stable, cmd_ready = 0, psel = 0 throughout.
- Reset mid-ACCESS: presetn pulsed low during ACCESS -> psel, penable, pwakeup, rsp_valid = 0 immediately (asynchronous); after release cmd_ready = 1 and no stale response appears.
